// File: rtl/hid_xbox_report_decoder.sv
// Xbox360 HID report decoder: filter, field extract, stick dead-zone (HID_DEADZONE_EN),
// change-only valid/ready output and stale-controller timeout.
module hid_xbox_report_decoder #(
  parameter int C_report_bytes = 20,
  parameter int C_clk_hz       = 6000000,
  parameter int C_timeout_ms   = 100,
  parameter int C_deadzone     = 4096
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [C_report_bytes*8-1:0] hid_report,
  input  logic                        hid_valid,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [15:0]                 buttons,
  output logic [7:0]                  trig_l,
  output logic [7:0]                  trig_r,
  output logic [15:0]                 stick_lx,
  output logic [15:0]                 stick_ly,
  output logic [15:0]                 stick_rx,
  output logic [15:0]                 stick_ry,
  output logic                        stale,
  output logic [7:0]                  drop_count,
  output logic [15:0]                 report_count
);

  localparam int unsigned C_t  = (C_clk_hz / 1000) * C_timeout_ms;
  localparam int          C_tw = $clog2(C_t + 1);
  localparam logic [C_tw-1:0] C_tmax = C_tw'(C_t);

  // Only bytes 0..13 carry fields used here.
  logic [111:0] rep_q, rep_d;
  logic         rep_vld_q, rep_vld_d;
  logic [95:0]  dec_q, dec_d;
  logic         dec_vld_q, dec_vld_d;
  logic [95:0]  out_q, out_d;
  logic         out_valid_q, out_valid_d;
  logic         force_q, force_d;
  logic         stale_q, stale_d;
  logic [C_tw-1:0] tmo_q, tmo_d;
  logic [7:0]   drop_q, drop_d;
  logic [15:0]  rcnt_q, rcnt_d;
  logic         load;

  generate
    if (C_report_bytes > 14) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^hid_report[C_report_bytes*8-1:112];
    end
  endgenerate

`ifndef HID_DEADZONE_EN
  logic [31:0] unused_dz;
  assign unused_dz = 32'(C_deadzone);
`endif

  function automatic logic [15:0] dz(input logic [15:0] v);
`ifdef HID_DEADZONE_EN
    logic [15:0] mag;
    // -32768 has no positive twin; clamp its magnitude to 32767.
    mag = v[15] ? ((v == 16'h8000) ? 16'h7FFF : (~v + 16'd1)) : v;
    dz  = ({16'h0000, mag} < 32'(C_deadzone)) ? 16'h0000 : v;
`else
    dz = v;
`endif
  endfunction

  always_comb begin
    rep_d     = hid_valid ? hid_report[111:0] : rep_q;
    rep_vld_d = hid_valid;

    dec_vld_d = rep_vld_q && (rep_q[7:0] == 8'h00) && (rep_q[15:8] == 8'h14);
    dec_d     = dec_q;
    if (dec_vld_d) begin
      dec_d = {rep_q[31:16], rep_q[39:32], rep_q[47:40],
               dz(rep_q[63:48]), dz(rep_q[79:64]),
               dz(rep_q[95:80]), dz(rep_q[111:96])};
    end
  end

  assign load = dec_vld_q && ((dec_q != out_q) || force_q);

  always_comb begin
    out_d       = load ? dec_q : out_q;
    out_valid_d = out_valid_q;
    if (load)
      out_valid_d = 1'b1;
    else if (out_valid_q && out_ready)
      out_valid_d = 1'b0;

    drop_d = drop_q;
    if (load && out_valid_q && !out_ready && (drop_q != 8'hFF))
      drop_d = drop_q + 8'd1;

    rcnt_d = dec_vld_q ? rcnt_q + 16'd1 : rcnt_q;

    if (hid_valid)
      tmo_d = '0;
    else if (tmo_q == C_tmax)
      tmo_d = tmo_q;
    else
      tmo_d = tmo_q + C_tw'(1);

    // A timeout expiring in the same cycle as a load wins, so stale is never missed.
    force_d = force_q;
    stale_d = stale_q;
    if (load) begin
      force_d = 1'b0;
      stale_d = 1'b0;
    end
    if (tmo_q == C_tmax) begin
      force_d = 1'b1;
      stale_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_q       <= '0;
      rep_vld_q   <= 1'b0;
      dec_q       <= '0;
      dec_vld_q   <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      force_q     <= 1'b1;
      stale_q     <= 1'b1;
      tmo_q       <= '0;
      drop_q      <= '0;
      rcnt_q      <= '0;
    end else begin
      rep_q       <= rep_d;
      rep_vld_q   <= rep_vld_d;
      dec_q       <= dec_d;
      dec_vld_q   <= dec_vld_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      force_q     <= force_d;
      stale_q     <= stale_d;
      tmo_q       <= tmo_d;
      drop_q      <= drop_d;
      rcnt_q      <= rcnt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign buttons      = out_q[95:80];
  assign trig_l       = out_q[79:72];
  assign trig_r       = out_q[71:64];
  assign stick_lx     = out_q[63:48];
  assign stick_ly     = out_q[47:32];
  assign stick_rx     = out_q[31:16];
  assign stick_ry     = out_q[15:0];
  assign stale        = stale_q;
  assign drop_count   = drop_q;
  assign report_count = rcnt_q;

endmodule

// File: tb/tb_hid_xbox_report_decoder.sv
// Directed bench for hid_xbox_report_decoder (1 ms timeout at 6 MHz => 6000 cycles).
module tb_hid_xbox_report_decoder;

  logic         clk = 1'b0;
  logic         reset;
  logic [159:0] hid_report;
  logic         hid_valid;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  buttons;
  logic [7:0]   trig_l, trig_r;
  logic [15:0]  stick_lx, stick_ly, stick_rx, stick_ry;
  logic         stale;
  logic [7:0]   drop_count;
  logic [15:0]  report_count;

  int tests = 0;
  int fails = 0;

  hid_xbox_report_decoder #(
    .C_report_bytes(20), .C_clk_hz(6000000), .C_timeout_ms(1), .C_deadzone(4096)
  ) dut (
    .clk(clk), .reset(reset), .hid_report(hid_report), .hid_valid(hid_valid),
    .out_valid(out_valid), .out_ready(out_ready), .buttons(buttons),
    .trig_l(trig_l), .trig_r(trig_r), .stick_lx(stick_lx), .stick_ly(stick_ly),
    .stick_rx(stick_rx), .stick_ry(stick_ry), .stale(stale),
    .drop_count(drop_count), .report_count(report_count)
  );

  always #5 clk = ~clk;

  function automatic logic [159:0] mk(input logic [7:0] b1, input logic [15:0] btn,
                                      input logic [15:0] lx, input logic [15:0] ly,
                                      input logic [15:0] rx, input logic [15:0] ry);
    mk = {48'hAAAA_AAAA_AAAA, ry, rx, ly, lx, 8'h22, 8'h11, btn, b1, 8'h00};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [159:0] d);
    @(posedge clk); #1;
    hid_report = d;
    hid_valid  = 1'b1;
    @(posedge clk); #1;
    hid_valid  = 1'b0;
  endtask

  logic [159:0] d2, d4, dr;
  logic [15:0]  exp_lx, exp_ry;
  logic         seen;

  initial begin
`ifdef HID_DEADZONE_EN
    exp_lx = 16'h0000; exp_ry = 16'h0000;
`else
    exp_lx = 16'h0800; exp_ry = 16'h0FFF;
`endif
    d2 = mk(8'h14, 16'h0010, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000);
    d4 = mk(8'h14, 16'h0010, 16'h0800, 16'hF000, 16'h8000, 16'h0FFF);
    dr = mk(8'h03, 16'h5555, 16'h1234, 16'h1234, 16'h1234, 16'h1234);
    reset = 1'b1; hid_valid = 1'b0; hid_report = '0; out_ready = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(2);
    check("rst_stale", 32'(stale), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_rcnt", 32'(report_count), 32'd0);
    check("rst_btn", 32'(buttons), 32'd0);

    // first accepted report: latency 3
    send(d2);
    tick(1);
    check("first_lat2_valid", 32'(out_valid), 32'd0);
    tick(1);
    check("first_valid", 32'(out_valid), 32'd1);
    check("first_btn", 32'(buttons), 32'h0010);
    check("first_lx", 32'(stick_lx), 32'h7FFF);
    check("first_stale", 32'(stale), 32'd0);
    check("first_rcnt", 32'(report_count), 32'd1);
    out_ready = 1'b1;
    tick(1);
    check("accept_valid", 32'(out_valid), 32'd0);
    check("accept_hold_btn", 32'(buttons), 32'h0010);

    // 5 identical back-to-back reports: no update
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      hid_report = d2; hid_valid = 1'b1;
      seen |= out_valid;
    end
    @(posedge clk); #1;
    hid_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      seen |= out_valid;
    end
    check("repeat_no_valid", 32'(seen), 32'd0);
    check("repeat_rcnt", 32'(report_count), 32'd6);

    // dead-zone boundaries
    send(d4);
    tick(2);
    check("dz_valid", 32'(out_valid), 32'd1);
    check("dz_lx", 32'(stick_lx), 32'(exp_lx));
    check("dz_ly", 32'(stick_ly), 32'hF000);
    check("dz_rx_min", 32'(stick_rx), 32'h8000);
    check("dz_ry", 32'(stick_ry), 32'(exp_ry));
    check("dz_rcnt", 32'(report_count), 32'd7);
    tick(1);
    check("dz_accept", 32'(out_valid), 32'd0);

    // latest wins while stalled
    out_ready = 1'b0;
    send(mk(8'h14, 16'h0001, 16'h0800, 16'hF000, 16'h8000, 16'h0FFF));
    send(mk(8'h14, 16'h0002, 16'h0800, 16'hF000, 16'h8000, 16'h0FFF));
    send(mk(8'h14, 16'h0003, 16'h0800, 16'hF000, 16'h8000, 16'h0FFF));
    tick(3);
    check("stall_valid", 32'(out_valid), 32'd1);
    check("stall_btn", 32'(buttons), 32'h0003);
    check("stall_ly", 32'(stick_ly), 32'hF000);
    check("stall_drop", 32'(drop_count), 32'd2);
    check("stall_rcnt", 32'(report_count), 32'd10);
    out_ready = 1'b1;
    tick(1);
    check("stall_accept", 32'(out_valid), 32'd0);

    // filtered report
    send(dr);
    tick(4);
    check("rej_valid", 32'(out_valid), 32'd0);
    check("rej_rcnt", 32'(report_count), 32'd10);
    check("rej_btn", 32'(buttons), 32'h0003);

    // rejected reports still restart the timeout
    tick(5900);
    send(dr);
    tick(5900);
    check("tmo_restart_stale", 32'(stale), 32'd0);
    tick(200);
    check("tmo_stale", 32'(stale), 32'd1);

    // identical report after timeout is re-emitted
    out_ready = 1'b0;
    send(mk(8'h14, 16'h0003, 16'h0800, 16'hF000, 16'h8000, 16'h0FFF));
    tick(1);
    check("force_pre_stale", 32'(stale), 32'd1);
    check("force_pre_valid", 32'(out_valid), 32'd0);
    tick(1);
    check("force_valid", 32'(out_valid), 32'd1);
    check("force_stale", 32'(stale), 32'd0);
    check("force_btn", 32'(buttons), 32'h0003);
    check("force_rcnt", 32'(report_count), 32'd11);
    check("force_drop", 32'(drop_count), 32'd2);

    // reset with an update pending
    reset = 1'b1;
    #2;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_stale", 32'(stale), 32'd1);
    check("mid_rst_drop", 32'(drop_count), 32'd0);
    check("mid_rst_rcnt", 32'(report_count), 32'd0);
    tick(2);
    reset = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
